// File: rtl/lz4_token_decoder.sv
// rtl/lz4_token_decoder.sv - LZ4 token stream decoder with history buffer and copy expansion
// Optional offset validation against written history: define LZ4_DEC_OFFSET_CHECK_EN.
module lz4_token_decoder #(
  parameter int unsigned HB_ADDR_WIDTH = 16,
  parameter logic [3:0]  ERR_MARK      = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [45:0] i_token_data,
  input  logic        i_token_vld,
  output logic        i_token_rdy,
  output logic [12:0] o_data_data,
  output logic        o_data_vld,
  input  logic        o_data_rdy
);

  localparam int unsigned AW = HB_ADDR_WIDTH;
  localparam logic [1:0] KIND_LIT  = 2'd0;
  localparam logic [1:0] KIND_COPY = 2'd1;
  localparam logic [1:0] KIND_MARK = 2'd2;
  localparam logic [3:0] MARK_RESET = 4'h1;

  typedef enum logic [1:0] {IDLE, COPY_RD, COPY_DATA} state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] cp_off_q;
  logic [15:0]   remaining_q;
  logic          out_vld_q;
  logic [12:0]   out_data_q;
  logic [7:0]    rd_data_q;
  logic [7:0]    hb [0:(2**AW)-1];

  logic [1:0]    tok_kind;
  logic [7:0]    tok_sym;
  logic [AW-1:0] tok_off;
  logic [15:0]   tok_cnt;
  logic [3:0]    tok_mark;
  logic          free;
  logic          tok_acc;
  logic          tok_mark_reset;
  logic          off_err;
  logic [AW-1:0] rd_addr;
  logic          hb_we;
  logic          hb_re;
  logic [AW-1:0] hb_addr;
  logic [7:0]    hb_wdata;

  assign tok_kind = i_token_data[45:44];
  assign tok_sym  = i_token_data[43:36];
  assign tok_off  = i_token_data[20 +: AW];
  assign tok_cnt  = i_token_data[19:4];
  assign tok_mark = i_token_data[3:0];

  assign free           = !out_vld_q || o_data_rdy;
  assign i_token_rdy    = !rst && (state_q == IDLE) && free;
  assign tok_acc        = i_token_vld && i_token_rdy;
  assign tok_mark_reset = tok_acc && (tok_kind == KIND_MARK) && (tok_mark == MARK_RESET);
  assign rd_addr        = wr_ptr_q - cp_off_q - AW'(1);

  assign o_data_vld  = out_vld_q;
  assign o_data_data = out_data_q;

`ifdef LZ4_DEC_OFFSET_CHECK_EN
  logic [AW:0] valid_cnt_q;

  assign off_err = ({1'b0, tok_off} + (AW+1)'(1)) > valid_cnt_q;

  // Saturates once the top bit is set: the whole history is then valid.
  always_ff @(posedge clk) begin
    if (rst || tok_mark_reset) begin
      valid_cnt_q <= '0;
    end else if (hb_we && !valid_cnt_q[AW]) begin
      valid_cnt_q <= valid_cnt_q + (AW+1)'(1);
    end
  end
`else
  assign off_err = 1'b0;
`endif

  // Reads and writes never share a cycle, so one address port suffices.
  always_comb begin
    hb_we    = 1'b0;
    hb_re    = 1'b0;
    hb_addr  = wr_ptr_q;
    hb_wdata = rd_data_q;
    if (state_q == COPY_RD) begin
      hb_re   = !rst;
      hb_addr = rd_addr;
    end else if (state_q == COPY_DATA) begin
      hb_we = free && !rst;
    end else if (tok_acc && tok_kind == KIND_LIT) begin
      hb_we    = 1'b1;
      hb_wdata = tok_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (hb_we) begin
      hb[hb_addr] <= hb_wdata;
    end
    if (hb_re) begin
      rd_data_q <= hb[hb_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cp_off_q    <= '0;
      remaining_q <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (free) begin
        out_vld_q <= 1'b0;
      end
      if (hb_we) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case (state_q)
        IDLE: begin
          if (tok_acc) begin
            case (tok_kind)
              KIND_LIT: begin
                out_vld_q  <= 1'b1;
                out_data_q <= {1'b0, tok_sym, 4'h0};
              end
              KIND_COPY: begin
                if (off_err) begin
                  out_vld_q  <= 1'b1;
                  out_data_q <= {1'b1, 8'h00, ERR_MARK};
                end else begin
                  cp_off_q    <= tok_off;
                  remaining_q <= tok_cnt;
                  state_q     <= COPY_RD;
                end
              end
              KIND_MARK: begin
                out_vld_q  <= 1'b1;
                out_data_q <= {1'b1, 8'h00, tok_mark};
                if (tok_mark == MARK_RESET) begin
                  wr_ptr_q <= '0;
                end
              end
              default: begin
              end
            endcase
          end
        end
        COPY_RD: begin
          state_q <= COPY_DATA;
        end
        COPY_DATA: begin
          if (free) begin
            out_vld_q  <= 1'b1;
            out_data_q <= {1'b0, rd_data_q, 4'h0};
            if (remaining_q == 16'd0) begin
              state_q <= IDLE;
            end else begin
              remaining_q <= remaining_q - 16'd1;
              state_q     <= COPY_RD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz4_token_decoder.sv
// tb/tb_lz4_token_decoder.sv - scoreboard bench for lz4_token_decoder (small history buffer)
`timescale 1ns/1ps
module tb_lz4_token_decoder;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [45:0] i_token_data;
  logic        i_token_vld;
  logic        i_token_rdy;
  logic [12:0] o_data_data;
  logic        o_data_vld;
  logic        o_data_rdy;

  lz4_token_decoder #(.HB_ADDR_WIDTH(AW), .ERR_MARK(4'hF)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_token_data (i_token_data),
    .i_token_vld  (i_token_vld),
    .i_token_rdy  (i_token_rdy),
    .o_data_data  (o_data_data),
    .o_data_vld   (o_data_vld),
    .o_data_rdy   (o_data_rdy)
  );

  always #5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [12:0] exp_q [$];
  logic [7:0]  hist [$];
  logic        stall_q = 1'b0;
  logic [12:0] stall_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, hold/ready checks while stalled.
  always @(negedge clk) begin
    if (stall_q) begin
      check_eq("hold_vld", {31'b0, o_data_vld}, 32'd1);
      check_eq("hold_data", {19'b0, o_data_data}, {19'b0, stall_data});
    end
    if (!rst && o_data_vld) begin
      if (!o_data_rdy) begin
        check_eq("tok_rdy_in_stall", {31'b0, i_token_rdy}, 32'd0);
      end else if (exp_q.size() == 0) begin
        check_eq("out_while_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        check_eq("out_data", {19'b0, o_data_data}, {19'b0, exp_q.pop_front()});
      end
    end
    stall_q    = !rst && o_data_vld && !o_data_rdy;
    stall_data = o_data_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    hist.push_back(b);
    exp_q.push_back({1'b0, b, 4'h0});
  endtask

  task automatic send_token(input logic [1:0] kind, input logic [7:0] sym,
                            input int off, input int cnt, input logic [3:0] mark);
    int  n;
    bit  err;
    n = 0;
    err = 1'b0;
    i_token_data = {kind, sym, 16'(off), 16'(cnt), mark};
    i_token_vld  = 1'b1;
    @(negedge clk);
    while (!i_token_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!i_token_rdy) begin
      check_eq("tok_accept_timeout", 32'(n), 32'd0);
      i_token_vld = 1'b0;
      return;
    end
    case (kind)
      2'd0: push_byte(sym);
      2'd1: begin
`ifdef LZ4_DEC_OFFSET_CHECK_EN
        if (off + 1 > ((hist.size() > DEPTH) ? DEPTH : hist.size())) err = 1'b1;
`endif
        if (err) exp_q.push_back({1'b1, 8'h00, 4'hF});
        else for (int i = 0; i <= cnt; i++) push_byte(hist[hist.size() - 1 - off]);
      end
      2'd2: begin
        exp_q.push_back({1'b1, 8'h00, mark});
        if (mark == 4'h1) hist.delete();
      end
      default: ;
    endcase
    step();
    i_token_vld  = 1'b0;
    i_token_data = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
    $fatal(1);
  end

  initial begin
    int n;
    rst          = 1'b1;
    i_token_vld  = 1'b0;
    i_token_data = '0;
    o_data_rdy   = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_vld", {31'b0, o_data_vld}, 32'd0);
    check_eq("rst_data", {19'b0, o_data_data}, 32'd0);
    check_eq("rst_tok_rdy", {31'b0, i_token_rdy}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_tok_rdy", {31'b0, i_token_rdy}, 32'd1);
    step();

    // Single literal: one-cycle pulse right after accept.
    send_token(2'd0, 8'h41, 0, 0, 4'h0);
    @(negedge clk);
    check_eq("lit_vld", {31'b0, o_data_vld}, 32'd1);
    check_eq("lit_data", {19'b0, o_data_data}, 32'h0410);
    @(negedge clk);
    check_eq("lit_pulse", {31'b0, o_data_vld}, 32'd0);
    step();

    // Overlapped copy with first-byte latency.
    send_token(2'd0, 8'h61, 0, 0, 4'h0);
    send_token(2'd0, 8'h62, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 1, 3, 4'h0);
    @(negedge clk);
    check_eq("copy_lat1_vld", {31'b0, o_data_vld}, 32'd0);
    check_eq("copy_rd_tok_rdy", {31'b0, i_token_rdy}, 32'd0);
    @(negedge clk);
    check_eq("copy_lat2_vld", {31'b0, o_data_vld}, 32'd0);
    check_eq("copy_data_tok_rdy", {31'b0, i_token_rdy}, 32'd0);
    @(negedge clk);
    check_eq("copy_lat3_vld", {31'b0, o_data_vld}, 32'd1);
    step();
    wait_drain();

    // Run-length copy under a 5-cycle stall.
    send_token(2'd0, 8'h7A, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 0, 3, 4'h0);
    o_data_rdy = 1'b0;
    repeat (5) step();
    o_data_rdy = 1'b1;
    wait_drain();

    // Overlapped copy under random backpressure.
    send_token(2'd0, 8'h31, 0, 0, 4'h0);
    send_token(2'd0, 8'h32, 0, 0, 4'h0);
    send_token(2'd0, 8'h33, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 2, 8, 4'h0);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      o_data_rdy = 1'($urandom_range(0, 1));
      step();
    end
    o_data_rdy = 1'b1;
    wait_drain();

    // Reserved kind is dropped silently.
    send_token(2'd3, 8'hEE, 0, 0, 4'h0);
    send_token(2'd0, 8'h99, 0, 0, 4'h0);
    wait_drain();

    // History wrap-around and marker output.
    send_token(2'd2, 8'h00, 0, 0, 4'h1);
    for (int i = 0; i < 20; i++) send_token(2'd0, 8'(i), 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 2, 1, 4'h0);
    send_token(2'd1, 8'h00, 15, 2, 4'h0);
    send_token(2'd2, 8'h00, 0, 0, 4'h3);
    wait_drain();

`ifdef LZ4_DEC_OFFSET_CHECK_EN
    send_token(2'd2, 8'h00, 0, 0, 4'h1);
    send_token(2'd0, 8'h55, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 4, 0, 4'h0);
    send_token(2'd1, 8'h00, 0, 1, 4'h0);
    wait_drain();
`endif

    // Reset in the middle of a long copy.
    send_token(2'd0, 8'h10, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 0, 30, 4'h0);
    n = 0;
    @(negedge clk);
    while (exp_q.size() > 28 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("midcopy_progress_timeout", {31'b0, (n < 100)}, 32'd1);
    step();
    rst = 1'b1;
    exp_q.delete();
    hist.delete();
    step();
    @(negedge clk);
    check_eq("midrst_vld", {31'b0, o_data_vld}, 32'd0);
    check_eq("midrst_tok_rdy", {31'b0, i_token_rdy}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_tok_rdy", {31'b0, i_token_rdy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("postrst_quiet", {31'b0, o_data_vld}, 32'd0);
    end
    step();
    send_token(2'd0, 8'h22, 0, 0, 4'h0);
    send_token(2'd1, 8'h00, 0, 1, 4'h0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lz4_token_decoder.md
Name: lz4_token_decoder

Overview:
- Consumes the LZ4 token stream produced by the dbe LZ4 encoder and reconstructs the original byte/mark stream.
- Keeps an internal history buffer (HB) and expands copy-pointer tokens byte by byte.
- Sits between the token channel and the data consumer, and uses the same channel packings as the encoder, so encoder→decoder loopback is bit-exact.

Parameters:
- HB_ADDR_WIDTH, 16: history depth is 2^HB_ADDR_WIDTH bytes. cp_off is truncated to this width.
- ERR_MARK, 4'hF: mark value emitted on a detected offset error. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_token_data  in  46  [45:44] kind, [43:36] lt_sym, [35:20] cp_off, [19:4] cp_cnt, [3:0] mark
- i_token_vld  in  1  token valid
- i_token_rdy  out  1  token ready
- o_data_data  out  13  [12] is_mark, [11:4] data, [3:0] mark
- o_data_vld  out  1  data valid
- o_data_rdy  in  1  data ready

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Values on reset:
  - Outputs: o_data_vld=0, o_data_data=0, i_token_rdy=0.
  - Internal: state=IDLE, wr_ptr=0, remaining=0, valid_cnt=0.
  - HB RAM contents are not cleared.
- Output stage: one registered entry.
  - "free" = !o_data_vld || o_data_rdy.
  - o_data_data is held stable while o_data_vld && !o_data_rdy.
- i_token_rdy = (state==IDLE) && free. This is combinational from o_data_rdy.
- Kinds:
  - 0 LITERAL: on accept, load output {0, lt_sym, 4'h0}, write HB[wr_ptr]=lt_sym, wr_ptr++. o_data_vld rises in the next cycle.
  - 1 COPY: distance = cp_off+1, length = cp_cnt+1 (1..65536).
    - On accept: latch cp_off, set remaining=cp_cnt, go to COPY_RD.
  - 2 MARKER: emit {1, 8'h00, mark}.
    - If mark==4'h1 (RESET): wr_ptr<=0 and valid_cnt<=0 in the same cycle.
  - 3 reserved: accept and drop. No output.
- Copy FSM:
  - COPY_RD: issue synchronous HB read at addr = wr_ptr − cp_off − 1 (mod 2^HB_ADDR_WIDTH). Always go to COPY_DATA next cycle.
  - COPY_DATA: wait until free. Then:
    - load output {0, rd_data, 4'h0};
    - write HB[wr_ptr]=rd_data, wr_ptr++;
    - if remaining==0 go to IDLE, else remaining-- and go to COPY_RD.
- Copy throughput and latency:
  - 1 byte per 2 cycles when unstalled.
  - First copy byte is valid 3 cycles after token accept.
- Overlap (distance ≤ length) works: each byte is written before the next read is issued.
- HB RAM: single-port inferred array. Write-then-read of the same address in consecutive cycles returns the new data.
- Wrap-around:
  - wr_ptr and read address wrap modulo 2^HB_ADDR_WIDTH.
  - valid_cnt counts written bytes and saturates at 2^HB_ADDR_WIDTH.
- Reset mid-copy: the copy is aborted and the pending output is dropped. No partial token resumes after reset.
- Back-to-back tokens:
  - A literal can be accepted every cycle while o_data_rdy=1.
  - No token is accepted during COPY_RD or COPY_DATA.

Optional Feature:
- Macro: LZ4_DEC_OFFSET_CHECK_EN.
- Defined:
  - On COPY accept, if cp_off+1 > valid_cnt, the copy is not performed.
  - Instead a single {1, 8'h00, ERR_MARK} is emitted.
  - wr_ptr is unchanged and the decoder returns to IDLE.
- Not defined: no check. The copy reads whatever the HB holds; results for invalid offsets are undefined. valid_cnt logic may be removed.

Test Plan:
- Literal: token kind0 lt_sym=0x41 with o_data_rdy=1 → next cycle o_data_data=0x0410, o_data_vld=1 for exactly 1 cycle.
- Overlapped copy: LIT 0x61, LIT 0x62, then COPY cp_off=1 cp_cnt=3 → data bytes 61 62 61 62 61 62 in order; first copy byte 3 cycles after the copy is accepted.
- Run-length: LIT 0x7A, then COPY cp_off=0 cp_cnt=3 → five 0x7A bytes.
- Backpressure: deassert o_data_rdy for 5 cycles during the COPY above →
  - o_data_data is held stable;
  - i_token_rdy=0 throughout;
  - no byte lost or duplicated.
- Wrap and mark, with HB_ADDR_WIDTH=4:
  - 20 literals 0x00..0x13, then COPY cp_off=2 cp_cnt=1 → bytes 0x11 0x12.
  - MARKER mark=0x3 → o_data_data=0x1003.
- Reset and check:
  - Assert rst mid-copy → o_data_vld=0 next cycle, then IDLE.
  - With LZ4_DEC_OFFSET_CHECK_EN: MARKER mark=1, LIT 0x55, COPY cp_off=4 → single output 0x100F, no data bytes.
